// File: rtl/replace_num_inserter_pkg.sv
// replace_num_inserter_pkg: shared widths, depth and counter helpers for the replace_num inserter.
`ifndef UART_REPLACE_NUM_ADDR_WIDTH
`define UART_REPLACE_NUM_ADDR_WIDTH 4
`endif
`ifndef UART_REPLACE_NUM_DATA_WIDTH
`define UART_REPLACE_NUM_DATA_WIDTH 8
`endif
`ifndef UART_REPLACE_NUM_ADDR_SIZE
`define UART_REPLACE_NUM_ADDR_SIZE (1 << `UART_REPLACE_NUM_ADDR_WIDTH)
`endif
`ifndef REPLACE_NUM_COUNT_WIDTH
`define REPLACE_NUM_COUNT_WIDTH 16
`endif

package replace_num_inserter_pkg;
  localparam int RN_DATA_WIDTH  = `UART_REPLACE_NUM_DATA_WIDTH;
  localparam int RN_ADDR_WIDTH  = `UART_REPLACE_NUM_ADDR_WIDTH;
  localparam int RN_DEPTH       = `UART_REPLACE_NUM_ADDR_SIZE;
  localparam int RN_COUNT_WIDTH = `REPLACE_NUM_COUNT_WIDTH;

  function automatic logic [RN_COUNT_WIDTH-1:0] sat_inc(input logic [RN_COUNT_WIDTH-1:0] c);
    return &c ? c : c + 1'b1;
  endfunction
endpackage

// File: rtl/replace_num_inserter_if.sv
// replace_num_inserter_if: input stream, output stream and replace_num_mem read port of the inserter.
interface replace_num_inserter_if
  import replace_num_inserter_pkg::*;
#(
  parameter int DATA_WIDTH = RN_DATA_WIDTH,
  parameter int ADDR_WIDTH = RN_ADDR_WIDTH
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic                  mem_rd_en;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_replaced;

  modport slave (
    input  in_data, in_valid, out_ready, mem_data, mem_valid,
    output in_ready, mem_rd_addr, mem_rd_en, out_data, out_valid, out_replaced
  );

  modport master (
    output in_data, in_valid, out_ready, mem_data, mem_valid,
    input  in_ready, mem_rd_addr, mem_rd_en, out_data, out_valid, out_replaced
  );
endinterface

// File: rtl/replace_num_seq_ctr.sv
// replace_num_seq_ctr: wrapping sequence index; seq_reset forces index 0 for the current cycle and restarts the count.
module replace_num_seq_ctr #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  seq_reset,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] idx
);
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;

  // current index honours a coinciding seq_reset; wrap is the natural overflow
  always_comb begin
    idx   = seq_reset ? '0 : idx_q;
    idx_d = idx + ADDR_WIDTH'(inc);
  end

  // index register
  always_ff @(posedge clk) begin
    idx_q <= !n_reset ? '0 : idx_d;
  end
endmodule

// File: rtl/replace_num_inserter.sv
// replace_num_inserter: tags stream words with a wrapping index and swaps in one-shot replacements from replace_num_mem.
// Defining REPLACE_NUM_COUNT_EN adds a saturating replace_count output.
module replace_num_inserter
  import replace_num_inserter_pkg::*;
#(
  parameter int DATA_WIDTH = RN_DATA_WIDTH,
  parameter int ADDR_WIDTH = RN_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      n_reset,
  input  logic                      seq_reset,
  replace_num_inserter_if.slave     bus
`ifdef REPLACE_NUM_COUNT_EN
  ,
  output logic [RN_COUNT_WIDTH-1:0] replace_count
`endif
);
  logic [ADDR_WIDTH-1:0] seq_idx;
  logic                  accept, load, rep_valid;
  logic [DATA_WIDTH-1:0] rep_data;
  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  s1_mem_pending_q, s1_mem_pending_d;
  logic [DATA_WIDTH-1:0] s1_rep_data_q, s1_rep_data_d;
  logic                  s1_rep_valid_q, s1_rep_valid_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_replaced_q, out_replaced_d;

  replace_num_seq_ctr #(.ADDR_WIDTH(ADDR_WIDTH)) u_seq_ctr (
    .clk      (clk),
    .n_reset  (n_reset),
    .seq_reset(seq_reset),
    .inc      (accept),
    .idx      (seq_idx)
  );

  // handshake, memory read request and next state of the two pipeline stages
  always_comb begin
    load             = s1_valid_q && (!out_valid_q || bus.out_ready);
    bus.in_ready     = n_reset && (!s1_valid_q || load);
    accept           = bus.in_valid && bus.in_ready;
    bus.mem_rd_en    = accept;
    bus.mem_rd_addr  = seq_idx;
    rep_valid        = s1_mem_pending_q ? bus.mem_valid : s1_rep_valid_q;
    rep_data         = s1_mem_pending_q ? bus.mem_data : s1_rep_data_q;
    s1_valid_d       = accept ? 1'b1 : (load ? 1'b0 : s1_valid_q);
    s1_data_d        = accept ? bus.in_data : s1_data_q;
    s1_mem_pending_d = accept;
    s1_rep_valid_d   = rep_valid;
    s1_rep_data_d    = rep_data;
    out_valid_d      = load ? 1'b1 : (bus.out_ready ? 1'b0 : out_valid_q);
    out_data_d       = load ? (rep_valid ? rep_data : s1_data_q) : out_data_q;
    out_replaced_d   = load ? rep_valid : out_replaced_q;
  end

  // pipeline registers; reset drops any in-flight words
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      s1_valid_q       <= 1'b0;
      s1_data_q        <= '0;
      s1_mem_pending_q <= 1'b0;
      s1_rep_data_q    <= '0;
      s1_rep_valid_q   <= 1'b0;
      out_valid_q      <= 1'b0;
      out_data_q       <= '0;
      out_replaced_q   <= 1'b0;
    end else begin
      s1_valid_q       <= s1_valid_d;
      s1_data_q        <= s1_data_d;
      s1_mem_pending_q <= s1_mem_pending_d;
      s1_rep_data_q    <= s1_rep_data_d;
      s1_rep_valid_q   <= s1_rep_valid_d;
      out_valid_q      <= out_valid_d;
      out_data_q       <= out_data_d;
      out_replaced_q   <= out_replaced_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_replaced = out_replaced_q;

`ifdef REPLACE_NUM_COUNT_EN
  logic [RN_COUNT_WIDTH-1:0] replace_count_q, replace_count_d;

  // count replaced words leaving the block; seq_reset wins over an increment
  always_comb begin
    replace_count_d = seq_reset ? '0 :
                      (out_valid_q && bus.out_ready && out_replaced_q) ? sat_inc(replace_count_q) :
                      replace_count_q;
  end

  // replace counter register
  always_ff @(posedge clk) begin
    replace_count_q <= !n_reset ? '0 : replace_count_d;
  end

  assign replace_count = replace_count_q;
`endif
endmodule

// File: tb/tb_replace_num_inserter.sv
// tb_replace_num_inserter: randomized scoreboard bench with a behavioural replace_num_mem and reference model.
module tb_replace_num_inserter;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int N  = 16;

  typedef struct {
    logic [DW-1:0] d;
    logic          r;
    int            t;
    logic          seen;
  } exp_t;

  logic clk = 0;
  logic n_reset = 0;
  logic seq_reset = 0;
  always #5 clk = ~clk;

  replace_num_inserter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
`ifdef REPLACE_NUM_COUNT_EN
  logic [15:0] replace_count;
`endif

  replace_num_inserter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .seq_reset(seq_reset),
    .bus      (bus)
`ifdef REPLACE_NUM_COUNT_EN
    ,
    .replace_count(replace_count)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic chk_lat = 0;
  logic rnd_rdy = 0;
  logic in_rst = 0;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", nm, got, exp, cyc);
    end
  endfunction

  function automatic void fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", nm, cyc);
  endfunction

  // replace_num_mem stand-in: one-cycle read latency, clears a location once read, erased by reset
  logic [DW-1:0] md [N];
  logic [N-1:0]  mv;
  logic          wr_en = 0;
  logic [AW-1:0] wr_addr = 0;
  logic [DW-1:0] wr_data = 0;
  always @(posedge clk) begin
    if (!n_reset) begin
      mv <= '0;
      bus.mem_valid <= 1'b0;
      bus.mem_data <= DW'($urandom);
    end else begin
      if (wr_en) begin
        md[wr_addr] <= wr_data;
        mv[wr_addr] <= 1'b1;
      end
      bus.mem_valid <= bus.mem_rd_en && mv[bus.mem_rd_addr];
      bus.mem_data <= bus.mem_rd_en ? md[bus.mem_rd_addr] : DW'($urandom);
      if (bus.mem_rd_en) mv[bus.mem_rd_addr] <= 1'b0;
    end
  end

  // reference model: what the stream should look like from the rules alone
  logic [DW-1:0] ref_d [N];
  logic [N-1:0]  ref_v = '0;
  int            ref_idx = 0;
  exp_t          q[$];
  exp_t          lg[$];

  // monitor: scoreboard checks at the falling edge
  always @(negedge clk) begin
    exp_t e;
    int idx;
    logic acc;
    cyc++;
    if (!n_reset) begin
      chk("rst_mem_rd_en", bus.mem_rd_en, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      if (in_rst) begin
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_replaced", bus.out_replaced, 0);
      end
      in_rst = 1;
      q.delete();
      ref_idx = 0;
      ref_v = '0;
    end else begin
      in_rst = 0;
      if (bus.out_valid) begin
        if (q.size() == 0) fail("spurious_out_valid");
        else begin
          chk("out_data", bus.out_data, q[0].d);
          chk("out_replaced", bus.out_replaced, q[0].r);
          if (chk_lat && !q[0].seen) chk("latency", cyc - q[0].t, 2);
          q[0].seen = 1;
          if (bus.out_ready) begin
            lg.push_back(q[0]);
            void'(q.pop_front());
          end
        end
      end
      acc = bus.in_valid && bus.in_ready;
      chk("mem_rd_en", bus.mem_rd_en, acc);
      if (acc) begin
        idx = seq_reset ? 0 : ref_idx;
        chk("mem_rd_addr", bus.mem_rd_addr, idx);
        e.d = ref_v[idx] ? ref_d[idx] : bus.in_data;
        e.r = ref_v[idx];
        e.t = cyc;
        e.seen = 0;
        ref_v[idx] = 1'b0;
        q.push_back(e);
        ref_idx = (idx + 1) % N;
      end else if (seq_reset) ref_idx = 0;
    end
  end

  // random downstream back-pressure when enabled
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_rdy) bus.out_ready = $urandom_range(0, 3) != 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic sr);
    int k = 0;
    bus.in_valid = 1;
    bus.in_data = d;
    seq_reset = sr;
    @(negedge clk);
    while (!bus.in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) fail("accept_timeout");
    tick();
    bus.in_valid = 0;
    seq_reset = 0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1;
    wr_addr = a;
    wr_data = d;
    ref_d[a] = d;
    ref_v[a] = 1'b1;
    tick();
    wr_en = 0;
  endtask

  task automatic drain();
    int k = 0;
    rnd_rdy = 0;
    bus.out_ready = 1;
    while (!(q.size() == 0 && !bus.out_valid) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k == 200) fail("drain_timeout");
    tick();
  endtask

  task automatic chk_lg(input int i, input logic [DW-1:0] d, input logic r);
    if (i >= lg.size()) fail("output_missing");
    else begin
      chk("word_data", lg[i].d, d);
      chk("word_replaced", lg[i].r, r);
    end
  endtask

  initial begin
    int acc;
    int nrep;
    bus.in_valid = 0;
    bus.in_data = 0;
    bus.out_ready = 0;
    repeat (4) tick();
    n_reset = 1;
    bus.out_ready = 1;
    tick();

    // empty memory, pass-through with latency check
    chk_lat = 1;
    lg.delete();
    for (int i = 0; i < 4; i++) send(DW'(8'h10 + i), 0);
    drain();
    chk_lat = 0;
    chk("pass_count", lg.size(), 4);
    for (int i = 0; i < 4; i++) chk_lg(i, DW'(8'h10 + i), 0);

    // replacement at index 2, then one-shot clear after seq_reset
    wr(2, 8'hAA);
    lg.delete();
    for (int i = 0; i < 4; i++) send(DW'(i), i == 0);
    drain();
    chk_lg(2, 8'hAA, 1);
    lg.delete();
    for (int i = 0; i < 4; i++) send(DW'(i), i == 0);
    drain();
    chk_lg(2, 8'h02, 0);

    // wrap: index 1 revisited at word 17 after being consumed at word 1
    wr(1, 8'h55);
    lg.delete();
    for (int i = 0; i < 20; i++) send(DW'(8'h20 + i), i == 0);
    drain();
    chk_lg(1, 8'h55, 1);
    chk_lg(17, 8'h31, 0);
    nrep = 0;
    foreach (lg[i]) nrep += int'(lg[i].r);
    chk("wrap_replacements", nrep, 1);

    // stall: only two words fit while downstream is blocked
    bus.out_ready = 0;
    bus.in_valid = 1;
    bus.in_data = 8'h40;
    acc = 0;
    repeat (5) begin
      logic a;
      @(negedge clk);
      a = bus.in_ready;
      tick();
      if (a) begin
        acc++;
        bus.in_data++;
      end
    end
    chk("stall_accepts", acc, 2);
    bus.in_valid = 0;
    drain();

    // random traffic, back-pressure, writes and seq_reset pulses
    rnd_rdy = 1;
    repeat (250) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) wr(AW'($urandom_range(0, N - 1)), DW'($urandom));
      else if (r < 8) send(DW'($urandom), $urandom_range(0, 19) == 0);
      else tick();
    end
    drain();

    // reset mid-stream: in-flight words dropped, first word afterwards reads address 0
    bus.out_ready = 0;
    send(8'h60, 0);
    send(8'h61, 0);
    bus.in_valid = 1;
    bus.in_data = 8'h62;
    tick();
    n_reset = 0;
    repeat (16) tick();
    n_reset = 1;
    bus.in_valid = 0;
    wr(0, 8'h99);
    lg.delete();
    bus.out_ready = 1;
    send(8'h77, 0);
    drain();
    chk("post_reset_count", lg.size(), 1);
    chk_lg(0, 8'h99, 1);

`ifdef REPLACE_NUM_COUNT_EN
    wr(1, 8'hA1);
    wr(2, 8'hA2);
    wr(3, 8'hA3);
    for (int i = 0; i < 5; i++) send(DW'(i), i == 0);
    drain();
    chk("replace_count", replace_count, 3);
    force dut.replace_count_q = 16'hFFFF;
    tick();
    release dut.replace_count_q;
    wr(5, 8'hB5);
    lg.delete();
    send(8'h55, 0);
    drain();
    chk_lg(0, 8'hB5, 1);
    chk("replace_count_sat", replace_count, 16'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
